// File: rtl/pc_next_unit.sv
// Registered program-counter unit: condition resolve, next-PC select, stall hold.
// Define PC_NEXT_RAS_EN to build the return-address stack; otherwise ret is a plain jump.
module pc_next_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      PC_STEP   = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             redirect,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_miss
);

  typedef enum logic [2:0] {
    C_NEVER  = 3'd0,
    C_ALWAYS = 3'd1,
    C_LT     = 3'd2,
    C_EQ     = 3'd3,
    C_GT     = 3'd4,
    C_LE     = 3'd5,
    C_GE     = 3'd6,
    C_NE     = 3'd7
  } cond_e;

  logic             lt, eq, gt, taken;
  logic [WIDTH-1:0] pc_d;
  logic             redirect_d, ret_miss_d;

  assign npc = pc + WIDTH'(PC_STEP);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lt    = a[WIDTH-1];
    eq    = (a == '0);
    gt    = !lt && !eq;
    taken = 1'b0;
    case (cond_e'(cond))
      C_NEVER:  taken = 1'b0;
      C_ALWAYS: taken = 1'b1;
      C_LT:     taken = lt;
      C_EQ:     taken = eq;
      C_GT:     taken = gt;
      C_LE:     taken = lt || eq;
      C_GE:     taken = !lt;
      C_NE:     taken = !eq;
      default:  taken = 1'b0;
    endcase
  end

`ifdef PC_NEXT_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr, ras_top_idx, ras_wr_idx;
  logic [CW-1:0]    ras_cnt;
  logic             ras_pop, ras_push, ras_swap, ras_inc, ras_we;

  // ras_ptr is the next free slot; the top of stack sits just below it.
  assign ras_top_idx = ras_ptr - PW'(1);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == CW'(RAS_DEPTH));

  always_comb begin
    ras_pop  = 1'b0;
    ras_push = 1'b0;
    ras_swap = 1'b0;
    if (!stall) begin
      ras_swap = call && ret;
      ras_pop  = ret && !call && !ras_empty;
      ras_push = call && taken && !ret;
    end
    ras_inc    = ras_push || (ras_swap && ras_empty);
    ras_we     = ras_push || ras_swap;
    ras_wr_idx = (ras_swap && !ras_empty) ? ras_top_idx : ras_ptr;
  end

  // NOTE: the stack storage has no reset; pointer and count alone define its contents.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_wr_idx] <= npc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_inc) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end
`else
  logic unused_ras;
  assign unused_ras = &{1'b0, call, RAS_DEPTH[0]};
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    pc_d       = pc;
    redirect_d = redirect;
    ret_miss_d = 1'b0;
    if (!stall) begin
      if (ret) begin
        redirect_d = 1'b1;
`ifdef PC_NEXT_RAS_EN
        if (!ras_empty) begin
          pc_d = ras_mem[ras_top_idx];
        end else begin
          pc_d       = target;
          ret_miss_d = 1'b1;
        end
`else
        pc_d = target;
`endif
      end else if (taken) begin
        pc_d       = target;
        redirect_d = 1'b1;
      end else begin
        pc_d       = npc;
        redirect_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      redirect <= 1'b0;
      ret_miss <= 1'b0;
    end else begin
      pc       <= pc_d;
      redirect <= redirect_d;
      ret_miss <= ret_miss_d;
    end
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter unit for the RISC processor datapath. Each cycle it resolves a branch condition on operand `a` against zero and updates the PC to the sequential address, the branch/jump target, or a return address. It generalises the combinational next-PC selection to a parametrised width, a full condition-code set, a stall handshake, and an optional return-address stack (RAS). It sits between the ALU/register-file outputs and the instruction-memory address port.

## Interface
Parameters:
- `WIDTH`, 32: PC, operand and target width.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries, power of two, at least 2. Used only with `PC_NEXT_RAS_EN`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hold PC and RAS; all other inputs are ignored.
- `cond` input 3: 0 never, 1 always, 2 lt, 3 eq, 4 gt, 5 le, 6 ge, 7 ne.
- `a` input WIDTH: signed operand compared against zero.
- `target` input WIDTH: branch/jump target (ALU output).
- `call` input 1: push the return address when the branch is taken.
- `ret` input 1: return request; pops the RAS.
- `pc` output WIDTH: current PC, registered.
- `npc` output WIDTH: `pc + PC_STEP`, combinational.
- `redirect` output 1: registered; 1 if the last PC update was not sequential.
- `ras_empty` output 1: RAS holds no entries.
- `ras_full` output 1: RAS holds `RAS_DEPTH` entries.
- `ret_miss` output 1: registered one-cycle pulse; a `ret` found the RAS empty.

## Operation
- Condition compare: `lt = a[WIDTH-1]`; `eq = (a == 0)`; `gt = !lt && !eq`. `le`, `ge` and `ne` are derived from these. `taken` is the condition selected by `cond`.
- Next-PC priority when `stall = 0`:
  1. `ret` with RAS non-empty: PC takes the top-of-stack value.
  2. `ret` with RAS empty: PC takes `target`, and `ret_miss` is set.
  3. `taken`: PC takes `target`.
  4. Otherwise: PC takes `npc`.
- `redirect` is 1 for cases 1–3 and 0 for case 4.
- Push: `call && taken && !ret` writes `npc` (the address after the call) and increments the pointer. On a push while full, the oldest entry is overwritten (circular buffer) and the count stays at `RAS_DEPTH`.
- Pop: `ret` with RAS non-empty decrements the pointer and count.
- Simultaneous `call` and `ret`: the pop takes effect, then the top entry is replaced with `npc`. Count is unchanged. With RAS empty, `npc` is pushed and the count becomes 1.
- Arithmetic: `npc` wraps modulo 2^WIDTH. The stack pointer wraps modulo `RAS_DEPTH`. The count saturates at `RAS_DEPTH` and at 0.
- `stall = 1`: `pc`, the RAS, and `redirect` hold their values; `ret_miss` is 0.

## Timing
- One-cycle latency: inputs sampled at rising edge N set `pc` from edge N onward.
- `ras_empty` and `ras_full` are decoded from the registered count and are valid in the same cycle as `pc`.
- Reset (asynchronous, at any time, including mid-call): `pc = RESET_PC`, `redirect = 0`, `ret_miss = 0`, RAS count = 0, pointer = 0, `ras_empty = 1`, `ras_full = 0`.
- First update occurs on the first rising edge after `rst_n` deasserts.
- The RAS storage array needs no reset; only the pointer and count are reset.

## Configuration
- Macro `PC_NEXT_RAS_EN`.
- Defined: the RAS is built as described above.
- Undefined:
  - No storage is built and `call` is ignored.
  - `ret` behaves as an unconditional jump to `target` and never raises `ret_miss`.
  - `ras_empty` is tied to 1, `ras_full` to 0, and `ret_miss` to 0.

## Test plan
- Reset/sequential: `RESET_PC=0`, release reset, `cond=0` -> `pc` = 0, 4, 8, 12 on successive edges; `redirect=0`.
- Conditions: `target=0x100`, `a=-5` with `cond=2` -> `pc=0x100`, `redirect=1`. `a=0` with `cond=7` -> sequential. Sweep all 8 codes × `a` in {-1, 0, 1}.
- Stall: assert `stall` for 3 cycles with `cond=1` -> `pc` unchanged; a `call` issued during the stall is not pushed.
- Call/return: at `pc=0x20`, `call`, `cond=1`, `target=0x200` -> `pc=0x200`. Then `ret` -> `pc=0x24`, `ras_empty=1`.
- RAS overflow/underflow (`RAS_DEPTH=4`):
  - 5 calls -> `ras_full=1`.
  - 4 rets return the 4 newest addresses.
  - A 5th `ret` with `target=0x80` -> `pc=0x80`, `ret_miss` pulses for one cycle.
- Reset mid-operation: push 2 entries, pulse `rst_n` low asynchronously -> `pc=RESET_PC` immediately, `ras_empty=1`; a following `ret` raises `ret_miss`.
